// File: rtl/regfile_pkg.sv
// Shared types and flag logic for the register-file front-end.
package regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

  localparam int RF_FLAG_ADDR_W = 32;

  typedef struct packed {
    logic zero;
    logic bypass;
  } rf_flags_t;

  // Zero wins over bypass so a write to x0 can never leak into a read of x0.
  function automatic rf_flags_t rf_calc_flags(
    input logic                      zero_reg,
    input logic                      wb_en,
    input logic [RF_FLAG_ADDR_W-1:0] wb_addr,
    input logic [RF_FLAG_ADDR_W-1:0] rs_addr
  );
    rf_flags_t f;
    f.zero   = zero_reg && (rs_addr == '0);
    f.bypass = wb_en && (wb_addr == rs_addr) && !f.zero;
    return f;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port: captures zero/bypass flags at request time and muxes the
// BRAM output against them, so the result is a snapshot of the request cycle.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  wb_en_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [DATA_WIDTH-1:0] bram_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  rf_flags_t             flags_d;
  logic                  zero_q;
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  assign flags_d = rf_calc_flags(ZERO_REG != 0, wb_en_i,
                                 RF_FLAG_ADDR_W'(wb_addr_i),
                                 RF_FLAG_ADDR_W'(rs_addr_i));

  // Zero flag set at reset so the port reads 0 before any request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q <= 1'b1;
      byp_q  <= 1'b0;
    end else if (req_i) begin
      zero_q <= flags_d.zero;
      byp_q  <= flags_d.bypass;
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_i && flags_d.bypass) begin
      byp_data_q <= wb_data_i;
    end
  end

  always_comb begin
    data_o = bram_data_i;
    if (zero_q) begin
      data_o = '0;
    end else if (byp_q) begin
      data_o = byp_data_q;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file front-end for two read-first BRAM copies: post-reset clear,
// 2R/1W port with same-cycle write->read bypass and hardwired x0.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32,
  parameter int ZERO_REG   = 1,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  ready_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  input  logic                  wb_en_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  bram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] bram_wr_data_o,
  output logic                  bram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] bram_rs1_addr_o,
  output logic [ADDR_WIDTH-1:0] bram_rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] bram_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] bram_rs2_data_i
);

  localparam logic                  ZERO_EN   = (ZERO_REG != 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_valid_q;
  logic                  rd_accept;
  logic                  wb_run;

  assign ready_o         = (state_q == RF_RUN);
  assign rd_accept       = ready_o && rd_req_i;
  assign wb_run          = ready_o && wb_en_i;
  assign rd_valid_o      = rd_valid_q;
  assign bram_rd_en_o    = rd_accept;
  assign bram_rs1_addr_o = rs1_addr_i;
  assign bram_rs2_addr_o = rs2_addr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RF_INIT;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_accept;
    end
  end

  // The clear write is gated by rst_ni so nothing reaches the BRAM while held in reset.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bram_wr_en_o   = 1'b0;
    bram_wr_addr_o = wb_addr_i;
    bram_wr_data_o = wb_data_i;
    case (state_q)
      RF_INIT: begin
        bram_wr_en_o   = rst_ni;
        bram_wr_addr_o = cnt_q;
        bram_wr_data_o = '0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        bram_wr_en_o = wb_en_i && !(ZERO_EN && (wb_addr_i == '0));
      end
      default: state_d = RF_INIT;
    endcase
  end

  regfile_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port1 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (rd_accept),
    .wb_en_i    (wb_run),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .rs_addr_i  (rs1_addr_i),
    .bram_data_i(bram_rs1_data_i),
    .data_o     (rs1_data_o)
  );

  regfile_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port2 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (rd_accept),
    .wb_en_i    (wb_run),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .rs_addr_i  (rs2_addr_i),
    .bram_data_i(bram_rs2_data_i),
    .data_o     (rs2_data_o)
  );

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl with two read-first BRAM models attached.
module tb_regfile_ctrl;

  localparam int DW = 32;
  localparam int NW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ready_o;
  logic          rd_req_i = 1'b0;
  logic [AW-1:0] rs1_addr_i = '0;
  logic [AW-1:0] rs2_addr_i = '0;
  logic          rd_valid_o;
  logic [DW-1:0] rs1_data_o, rs2_data_o;
  logic          wb_en_i = 1'b0;
  logic [AW-1:0] wb_addr_i = '0;
  logic [DW-1:0] wb_data_i = '0;
  logic          bram_wr_en_o;
  logic [AW-1:0] bram_wr_addr_o;
  logic [DW-1:0] bram_wr_data_o;
  logic          bram_rd_en_o;
  logic [AW-1:0] bram_rs1_addr_o, bram_rs2_addr_o;
  logic [DW-1:0] bram_rs1_data_i, bram_rs2_data_i;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] model[NW];
  logic [DW-1:0] mem1[NW];
  logic [DW-1:0] mem2[NW];

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ready_o        (ready_o),
    .rd_req_i       (rd_req_i),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rd_valid_o     (rd_valid_o),
    .rs1_data_o     (rs1_data_o),
    .rs2_data_o     (rs2_data_o),
    .wb_en_i        (wb_en_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .bram_wr_en_o   (bram_wr_en_o),
    .bram_wr_addr_o (bram_wr_addr_o),
    .bram_wr_data_o (bram_wr_data_o),
    .bram_rd_en_o   (bram_rd_en_o),
    .bram_rs1_addr_o(bram_rs1_addr_o),
    .bram_rs2_addr_o(bram_rs2_addr_o),
    .bram_rs1_data_i(bram_rs1_data_i),
    .bram_rs2_data_i(bram_rs2_data_i)
  );

  // Two read-first true-dual-port BRAM copies: port A writes, port B reads old data.
  initial begin
    for (int i = 0; i < NW; i++) begin
      mem1[i] = $urandom;
      mem2[i] = $urandom;
    end
  end

  always @(posedge clk) begin
    if (bram_wr_en_o) begin
      mem1[bram_wr_addr_o] <= bram_wr_data_o;
      mem2[bram_wr_addr_o] <= bram_wr_data_o;
    end
    if (bram_rd_en_o) begin
      bram_rs1_data_i <= mem1[bram_rs1_addr_o];
      bram_rs2_data_i <= mem2[bram_rs2_addr_o];
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: x0 is zero, a same-cycle write is visible to the read.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input logic we,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == '0) return '0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic step(input logic rq, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    exp_t e;
    rd_req_i = rq; rs1_addr_i = a1; rs2_addr_i = a2;
    wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
    #1;
    if (ready_o) begin
      chk("wr_en", {31'd0, bram_wr_en_o}, {31'd0, we && wa != '0});
      if (we && wa != '0) begin
        chk("wr_addr", {27'd0, bram_wr_addr_o}, {27'd0, wa});
        chk("wr_data", bram_wr_data_o, wd);
      end
      chk("rd_en", {31'd0, bram_rd_en_o}, {31'd0, rq});
      if (rq) begin
        e.d1 = ref_read(a1, we, wa, wd);
        e.d2 = ref_read(a2, we, wa, wd);
        sb_q.push_back(e);
      end
      if (we && wa != '0) model[wa] = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_wr_en", {31'd0, bram_wr_en_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_rd_en", {31'd0, bram_rd_en_o}, 32'd0);
    chk("rst_rs1", rs1_data_o, '0);
    chk("rst_rs2", rs2_data_o, '0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic clear_seq(input int n);
    for (int k = 0; k < n; k++) begin
      rd_req_i = 1'($urandom); wb_en_i = 1'($urandom);
      wb_addr_i = AW'($urandom); rs1_addr_i = AW'($urandom); rs2_addr_i = AW'($urandom);
      wb_data_i = $urandom;
      #1;
      chk("clr_addr", {27'd0, bram_wr_addr_o}, 32'(k));
      chk("clr_en", {31'd0, bram_wr_en_o}, 32'd1);
      chk("clr_data", bram_wr_data_o, '0);
      chk("init_rd_en", {31'd0, bram_rd_en_o}, 32'd0);
      chk("init_ready", {31'd0, ready_o}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops on every rd_valid_o, otherwise outputs must hold the last snapshot.
  initial begin
    logic [DW-1:0] last1, last2;
    exp_t e;
    last1 = '0; last2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        last1 = '0; last2 = '0;
      end else if (rd_valid_o) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: got rd_valid_o=1 expected 0 at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("rs1_data", rs1_data_o, e.d1);
          chk("rs2_data", rs2_data_o, e.d2);
          last1 = e.d1; last2 = e.d2;
        end
      end else begin
        chk("hold_rs1", rs1_data_o, last1);
        chk("hold_rs2", rs2_data_o, last2);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    apply_reset();
    clear_seq(NW);
    chk("ready_after_clear", {31'd0, ready_o}, 32'd1);
    for (int i = 0; i < NW; i++) model[i] = '0;

    for (int i = 0; i < NW; i++) step(1'b1, AW'(i), AW'(NW - 1 - i), 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);

    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(1'b1, 5'd5, 5'd5, 1'b0, '0, '0);

    step(1'b0, '0, '0, 1'b1, 5'd7, 32'h11);
    step(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22);
    step(1'b1, 5'd7, 5'd5, 1'b0, '0, '0);

    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 5'd0, 5'd7, 1'b0, '0, '0);

    step(1'b0, '0, '0, 1'b1, 5'd3, 32'h33);
    step(1'b1, 5'd3, 5'd3, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 5'd3, 32'h44);
    step(1'b1, 5'd3, 5'd3, 1'b0, '0, '0);

    for (int i = 0; i < 400; i++) begin
      logic narrow;
      narrow = 1'($urandom);
      step(1'($urandom), narrow ? AW'($urandom_range(0, 7)) : AW'($urandom),
           narrow ? AW'($urandom_range(0, 7)) : AW'($urandom),
           1'($urandom), narrow ? AW'($urandom_range(0, 7)) : AW'($urandom), $urandom);
    end
    step(1'b0, '0, '0, 1'b0, '0, '0);

    apply_reset();
    clear_seq(10);
    #1;
    chk("cnt_at_10", {27'd0, bram_wr_addr_o}, 32'd10);
    apply_reset();
    clear_seq(NW);
    chk("ready_after_reclear", {31'd0, ready_o}, 32'd1);
    for (int i = 0; i < NW; i++) model[i] = '0;

    for (int i = 0; i < 60; i++)
      step(1'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           1'($urandom), AW'($urandom_range(0, 7)), $urandom);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    chk("drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
